// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: FSM state encoding and the
// branch-mispredict condition.
package mem_stage_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_e;

    function automatic logic mispredict(input logic branch, input logic taken,
                                        input logic actual);
        return branch & (taken != actual);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              dm_req_valid;
    logic              dm_req_ready;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_rsp_valid;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output dm_req_valid, dm_we, dm_addr, dm_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rdata
    );

    modport slave (
        input  dm_req_valid, dm_we, dm_addr, dm_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rdata
    );
endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. When not capturing, a bubble is inserted:
// control bits clear while the data fields hold.
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              rdata_en_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] readdata_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              regwrite_o,
    output logic              memtoreg_o
);
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] readdata_q;
    logic [REG_W-1:0]  rd_q;
    logic              regwrite_q;
    logic              memtoreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q      <= '0;
            readdata_q <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            if (capture_i) begin
                alu_q      <= alu_i;
                rd_q       <= rd_i;
                regwrite_q <= regwrite_i;
                memtoreg_q <= memtoreg_i;
            end else begin
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end
            if (rdata_en_i) begin
                readdata_q <= rdata_i;
            end
        end
    end

    assign alu_o      = alu_q;
    assign readdata_o = readdata_q;
    assign rd_o       = rd_q;
    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage core: data-memory handshake, pipeline stall,
// access watchdog, branch redirect/flush and the MEM/WB register.
//
// state    | meaning
// IDLE     | no read outstanding; request driven whenever an access is pending
// WAIT_RSP | read accepted, waiting for dm_rsp_valid
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int WAIT_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_branch_mem,
    input  logic [DATA_W-1:0] pc_plus4_mem,
    input  logic [DATA_W-1:0] alu_mem,
    input  logic [DATA_W-1:0] writedata_mem,
    input  logic [REG_W-1:0]  rd_mem,
    input  logic              branch_mem,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic              memtoreg_mem,
    input  logic              regwrite_mem,
    input  logic              taken_mem,
    input  logic              branch_taken_mem,
    mem_stage_if.master       dm,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic [DATA_W-1:0] readdata_wb,
    output logic [DATA_W-1:0] alu_wb,
    output logic [REG_W-1:0]  rd_wb,
    output logic              regwrite_wb,
    output logic              memtoreg_wb,
    output logic              err_timeout
);
    localparam int CNT_W = $clog2(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic acc, at_limit, req_valid, wr_done, rd_accept, rd_done;
    logic raw_stall, timeout, mispred;

    assign acc       = memread_mem | memwrite_mem;
    assign at_limit  = (cnt_q == CNT_LAST);
    // Request is withheld in the abort cycle so nothing is accepted as the access is dropped.
    assign req_valid = (state_q == IDLE) & acc & ~rst & ~at_limit;
    assign wr_done   = req_valid & memwrite_mem & dm.dm_req_ready;
    assign rd_accept = req_valid & ~memwrite_mem & dm.dm_req_ready;
    assign rd_done   = (state_q == WAIT_RSP) & dm.dm_rsp_valid;
    assign raw_stall = acc & ~(wr_done | rd_done);
    assign timeout   = raw_stall & at_limit;
    assign stall     = raw_stall & ~timeout;

    assign dm.dm_req_valid = req_valid;
    assign dm.dm_we        = memwrite_mem;
    assign dm.dm_addr      = alu_mem;
    assign dm.dm_wdata     = writedata_mem;

    assign mispred   = ~stall & mispredict(branch_mem, taken_mem, branch_taken_mem);
    assign pc_src    = mispred;
    assign flush     = mispred;
    assign pc_target = (mispred & branch_taken_mem) ? pc_branch_mem : pc_plus4_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= stall ? cnt_q + CNT_W'(1) : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rd_accept) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rd_done | timeout | ~acc) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_timeout = err_q;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (~stall & ~timeout),
        .rdata_en_i (rd_done),
        .alu_i      (alu_mem),
        .rdata_i    (dm.dm_rdata),
        .rd_i       (rd_mem),
        .regwrite_i (regwrite_mem),
        .memtoreg_i (memtoreg_mem),
        .alu_o      (alu_wb),
        .readdata_o (readdata_wb),
        .rd_o       (rd_wb),
        .regwrite_o (regwrite_wb),
        .memtoreg_o (memtoreg_wb)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// multi-cycle sequences (load latency, timeout, reset mid-read, back-to-back).
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_branch_mem, pc_plus4_mem, alu_mem, writedata_mem;
    logic [4:0]  rd_mem;
    logic        branch_mem, memread_mem, memwrite_mem, memtoreg_mem, regwrite_mem;
    logic        taken_mem, branch_taken_mem;
    logic        stall, pc_src, flush;
    logic [31:0] pc_target, readdata_wb, alu_wb;
    logic [4:0]  rd_wb;
    logic        regwrite_wb, memtoreg_wb, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.DATA_W(32)) dm_bus ();

    mem_stage #(.DATA_W(32), .REG_W(5), .WAIT_LIMIT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_branch_mem    (pc_branch_mem),
        .pc_plus4_mem     (pc_plus4_mem),
        .alu_mem          (alu_mem),
        .writedata_mem    (writedata_mem),
        .rd_mem           (rd_mem),
        .branch_mem       (branch_mem),
        .memread_mem      (memread_mem),
        .memwrite_mem     (memwrite_mem),
        .memtoreg_mem     (memtoreg_mem),
        .regwrite_mem     (regwrite_mem),
        .taken_mem        (taken_mem),
        .branch_taken_mem (branch_taken_mem),
        .dm               (dm_bus),
        .stall            (stall),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .flush            (flush),
        .readdata_wb      (readdata_wb),
        .alu_wb           (alu_wb),
        .rd_wb            (rd_wb),
        .regwrite_wb      (regwrite_wb),
        .memtoreg_wb      (memtoreg_wb),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rdy, br, tk, btk, rw;
        logic [31:0] alu, wd, pcb, pcp4;
        logic        e_rv, e_we, e_stall, e_src, e_flush;
        logic [31:0] e_tgt;
        logic        e_rw;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        memread_mem = 0; memwrite_mem = 0; memtoreg_mem = 0; regwrite_mem = 0;
        branch_mem = 0; taken_mem = 0; branch_taken_mem = 0;
        dm_bus.dm_req_ready = 0; dm_bus.dm_rsp_valid = 0; dm_bus.dm_rdata = '0;
        alu_mem = '0; writedata_mem = '0; rd_mem = '0;
        pc_branch_mem = '0; pc_plus4_mem = 32'h4;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int rel;
        //         rd wr rdy br tk btk rw alu          wd           pcb          pcp4         rv we st src fl tgt          rw
        vecs[0] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h100, 32'hCAFE0001,32'h0,  32'h104,1'b1,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,   32'h0,       32'h200,32'h18, 1'b0,1'b0,1'b0,1'b1,1'b1,32'h200,1'b0};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   32'h0,       32'h300,32'h1C, 1'b0,1'b0,1'b0,1'b1,1'b1,32'h1C, 1'b0};
        vecs[3] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h55,  32'h0,       32'h400,32'h20, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h20, 1'b1};
        vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'hABCD,32'h0,       32'h0,  32'h24, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h24, 1'b1};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h40,  32'h0,       32'h500,32'h28, 1'b1,1'b0,1'b1,1'b0,1'b0,32'h28, 1'b0};
        vecs[6] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h60,  32'h77,      32'h0,  32'h2C, 1'b1,1'b1,1'b1,1'b0,1'b0,32'h2C, 1'b0};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h99,  32'h0,       32'h600,32'h30, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h30, 1'b1};

        // Reset state, with an access pending to show the request is masked.
        nop();
        rst = 1; memread_mem = 1; dm_bus.dm_rsp_valid = 1; dm_bus.dm_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("rst_req_valid", dm_bus.dm_req_valid, 0);
        tick(); tick();
        chk("rst_readdata_wb", readdata_wb, 0);
        chk("rst_alu_wb", alu_wb, 0);
        chk("rst_rd_wb", rd_wb, 0);
        chk("rst_regwrite_wb", regwrite_wb, 0);
        chk("rst_memtoreg_wb", memtoreg_wb, 0);
        chk("rst_err_timeout", err_timeout, 0);
        rst = 0;
        nop();
        tick();

        foreach (vecs[i]) begin
            memread_mem = vecs[i].rd; memwrite_mem = vecs[i].wr; memtoreg_mem = vecs[i].rd;
            regwrite_mem = vecs[i].rw; branch_mem = vecs[i].br; taken_mem = vecs[i].tk;
            branch_taken_mem = vecs[i].btk; dm_bus.dm_req_ready = vecs[i].rdy;
            alu_mem = vecs[i].alu; writedata_mem = vecs[i].wd; rd_mem = 5'(i + 1);
            pc_branch_mem = vecs[i].pcb; pc_plus4_mem = vecs[i].pcp4;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), dm_bus.dm_req_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_we", i), dm_bus.dm_we, vecs[i].e_we);
                chk($sformatf("v%0d_addr", i), dm_bus.dm_addr, vecs[i].alu);
                chk($sformatf("v%0d_wdata", i), dm_bus.dm_wdata, vecs[i].wd);
            end
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("v%0d_pc_src", i), pc_src, vecs[i].e_src);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
            chk($sformatf("v%0d_pc_target", i), pc_target, vecs[i].e_tgt);
            tick();
            chk($sformatf("v%0d_regwrite_wb", i), regwrite_wb, vecs[i].e_rw);
            if (!vecs[i].e_stall) begin
                chk($sformatf("v%0d_alu_wb", i), alu_wb, vecs[i].alu);
            end
        end
        nop();
        tick();

        // Load at 0x40: accepted after 2 wait cycles, response 3 cycles later.
        memread_mem = 1; memtoreg_mem = 1; regwrite_mem = 1; rd_mem = 5; alu_mem = 32'h40;
        for (int c = 0; c < 6; c++) begin
            dm_bus.dm_req_ready = (c == 2);
            dm_bus.dm_rsp_valid = (c == 5);
            dm_bus.dm_rdata     = (c == 5) ? 32'h12345678 : 32'hDEADBEEF;
            @(negedge clk);
            chk($sformatf("ld_c%0d_stall", c), stall, (c < 5));
            chk($sformatf("ld_c%0d_req_valid", c), dm_bus.dm_req_valid, (c <= 2));
            tick();
            chk($sformatf("ld_c%0d_regwrite_wb", c), regwrite_wb, (c == 5));
        end
        chk("ld_readdata_wb", readdata_wb, 32'h12345678);
        chk("ld_rd_wb", rd_wb, 5);
        chk("ld_alu_wb", alu_wb, 32'h40);
        chk("ld_memtoreg_wb", memtoreg_wb, 1);
        nop();
        tick();
        chk("ld_after_regwrite_wb", regwrite_wb, 0);

        // Load never accepted: watchdog releases on the 8th cycle.
        memread_mem = 1; memtoreg_mem = 1; regwrite_mem = 1; rd_mem = 7; alu_mem = 32'h70;
        rel = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall) begin
                rel = c;
                break;
            end
            tick();
        end
        chk("to_release_cycle", rel, 7);
        chk("to_req_valid_dropped", dm_bus.dm_req_valid, 0);
        tick();
        chk("to_err_timeout", err_timeout, 1);
        chk("to_regwrite_wb", regwrite_wb, 0);
        nop();
        tick(); tick(); tick();
        chk("to_err_sticky", err_timeout, 1);
        chk("to_stall_idle", stall, 0);

        // Reset while a read is outstanding, then a stray response.
        memread_mem = 1; regwrite_mem = 1; memtoreg_mem = 1; rd_mem = 9; alu_mem = 32'h44;
        dm_bus.dm_req_ready = 1;
        tick();
        dm_bus.dm_req_ready = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("rstmid_req_valid", dm_bus.dm_req_valid, 0);
        tick();
        chk("rstmid_readdata_wb", readdata_wb, 0);
        chk("rstmid_alu_wb", alu_wb, 0);
        chk("rstmid_rd_wb", rd_wb, 0);
        chk("rstmid_regwrite_wb", regwrite_wb, 0);
        chk("rstmid_memtoreg_wb", memtoreg_wb, 0);
        chk("rstmid_err_cleared", err_timeout, 0);
        rst = 0;
        dm_bus.dm_rsp_valid = 1; dm_bus.dm_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("stray_stall", stall, 1);
        chk("stray_req_valid", dm_bus.dm_req_valid, 1);
        tick();
        chk("stray_readdata_wb", readdata_wb, 0);
        chk("stray_regwrite_wb", regwrite_wb, 0);
        nop();
        tick();

        // Back-to-back loads against 1-cycle-latency memory.
        memread_mem = 1; memtoreg_mem = 1; regwrite_mem = 1; rd_mem = 3; alu_mem = 32'h80;
        dm_bus.dm_req_ready = 1;
        @(negedge clk);
        chk("b2b_a_accept_stall", stall, 1);
        tick();
        chk("b2b_a_bubble", regwrite_wb, 0);
        dm_bus.dm_req_ready = 0; dm_bus.dm_rsp_valid = 1; dm_bus.dm_rdata = 32'h11111111;
        @(negedge clk);
        chk("b2b_a_rsp_stall", stall, 0);
        tick();
        chk("b2b_a_readdata", readdata_wb, 32'h11111111);
        chk("b2b_a_rd", rd_wb, 3);
        chk("b2b_a_regwrite", regwrite_wb, 1);
        rd_mem = 4; alu_mem = 32'h84;
        dm_bus.dm_req_ready = 1; dm_bus.dm_rsp_valid = 0; dm_bus.dm_rdata = '0;
        tick();
        chk("b2b_b_bubble", regwrite_wb, 0);
        chk("b2b_b_hold", readdata_wb, 32'h11111111);
        dm_bus.dm_req_ready = 0; dm_bus.dm_rsp_valid = 1; dm_bus.dm_rdata = 32'h22222222;
        tick();
        chk("b2b_b_readdata", readdata_wb, 32'h22222222);
        chk("b2b_b_rd", rd_wb, 4);
        chk("b2b_b_regwrite", regwrite_wb, 1);
        nop();
        tick();
        chk("b2b_end_regwrite", regwrite_wb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
